// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - 3-cycle instruction sequencer feeding a 16-bit combinational ALU
// Optional overflow trap/halt is enabled by defining ALU_SEQ_OVF_TRAP_EN.
module alu_seq #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_code,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_ovf,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic              halted,
  input  logic              rf_load_en,
  input  logic [AW-1:0]     rf_load_addr,
  input  logic [DATA_W-1:0] rf_load_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [NREG];
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] res_q;
  logic              ovf_q;
  logic              legal_q;
  logic              ovf_set;

  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    case (op[4:3])
      2'b00:   ok = 1'b1;
      2'b01:   ok = (op[2:0] == 3'b000) || (op[2:0] == 3'b001) ||
                    (op[2:0] == 3'b010) || (op[2:0] == 3'b100);
      2'b10:   ok = !op[2];
      default: ok = (op[2:0] <= 3'b101);
    endcase
    return ok;
  endfunction

  // Only the arithmetic group reports overflow; other groups' ovf is don't-care.
  assign ovf_set  = (state == WB) && legal_q && (alu_code[4:3] == 2'b00) && ovf_q;

  assign wb_addr  = rd_q;
  assign wb_data  = res_q;
  assign dbg_data = rf[dbg_addr];

`ifdef ALU_SEQ_OVF_TRAP_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_code    <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      legal_q     <= 1'b0;
      wb_valid    <= 1'b0;
      ovf_sticky  <= 1'b0;
`ifdef ALU_SEQ_OVF_TRAP_EN
      halted_q    <= 1'b0;
`endif
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ovf_set) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Operands are read from the current array, so a coincident preload
          // of a source register is not visible to this instruction.
          if (rf_load_en) begin
            rf[rf_load_addr] <= rf_load_data;
          end
          if (instr_valid) begin
            alu_a       <= rf[instr_rs1];
            alu_b       <= rf[instr_rs2];
            alu_code    <= instr_op;
            rd_q        <= instr_rd;
            legal_q     <= op_legal(instr_op);
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end

        EXEC: begin
          res_q    <= alu_c;
          ovf_q    <= alu_ovf;
          wb_valid <= legal_q;
          state    <= WB;
        end

        WB: begin
          wb_valid <= 1'b0;
          if (legal_q) begin
            rf[rd_q] <= res_q;
          end
`ifdef ALU_SEQ_OVF_TRAP_EN
          if (ovf_set) begin
            halted_q <= 1'b1;
            state    <= HALT;
          end else begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
`else
          instr_ready <= 1'b1;
          state       <= IDLE;
`endif
        end

        HALT: begin
`ifdef ALU_SEQ_OVF_TRAP_EN
          if (ovf_clr) begin
            halted_q    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
`else
          instr_ready <= 1'b1;
          state       <= IDLE;
`endif
        end

        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq with a behavioural ALU
// Trap-mode expectations follow ALU_SEQ_OVF_TRAP_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  instr_op;
  logic [2:0]  instr_rd, instr_rs1, instr_rs2;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_code;
  logic        alu_ovf;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ovf_sticky, ovf_clr, halted;
  logic        rf_load_en;
  logic [2:0]  rf_load_addr, dbg_addr;
  logic [15:0] rf_load_data, dbg_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] rf_m [8];
  logic        sticky_m;
  logic [31:0] legal_mask;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .alu_c(alu_c), .alu_ovf(alu_ovf),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .halted(halted),
    .rf_load_en(rf_load_en), .rf_load_addr(rf_load_addr), .rf_load_data(rf_load_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU; non-arithmetic groups always raise ovf so it must be ignored.
  function automatic logic [16:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic v;
    logic signed [15:0] sa, sb;
    sa = a; sb = b; r = 16'h0; v = 1'b1;
    case (op[4:3])
      2'b00: begin
        if (!op[0]) begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
        else        begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      end
      2'b01: case (op[2:0])
        3'd0: r = a & b;  3'd1: r = a | b;  3'd2: r = a ^ b;  3'd4: r = ~a;
        default: r = 16'hDEAD;
      endcase
      2'b10: case (op[2:0])
        3'd0: r = a << b[3:0];
        3'd1: r = a >> b[3:0];
        3'd2: r = sa >>> b[3:0];
        3'd3: r = (a << b[3:0]) | (a >> (16 - b[3:0]));
        default: r = 16'hBEEF;
      endcase
      default: case (op[2:0])
        3'd0: r = {15'd0, sa == sb};  3'd1: r = {15'd0, sa < sb};
        3'd2: r = {15'd0, sa <= sb};  3'd3: r = {15'd0, sa > sb};
        3'd4: r = {15'd0, sa >= sb};  3'd5: r = {15'd0, sa != sb};
        default: r = 16'h5A5A;
      endcase
    endcase
    return {v, r};
  endfunction

  always_comb {alu_ovf, alu_c} = alu_fn(alu_code, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic load(input logic [2:0] addr, input logic [15:0] data);
    rf_load_en = 1'b1; rf_load_addr = addr; rf_load_data = data;
    @(posedge clk); #1;
    rf_load_en = 1'b0;
    rf_m[addr] = data;
  endtask

  task automatic clear_sticky();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    sticky_m = 1'b0;
    check("sticky_clr", ovf_sticky, sticky_m);
  endtask

  // Full instruction lifecycle, checked against the architectural model.
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit clr, input bit ld,
                       input logic [2:0] ld_addr, input logic [15:0] ld_data);
    logic [15:0] a, b, res;
    logic v, lg, sets;
    int n;
    a = rf_m[rs1]; b = rf_m[rs2];
    {v, res} = alu_fn(op, a, b);
    lg = legal_mask[op];
    n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("accept_wait", instr_ready, 1'b1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    ovf_clr = clr; rf_load_en = ld; rf_load_addr = ld_addr; rf_load_data = ld_data;
    @(posedge clk); #1;
    instr_valid = 1'b0; rf_load_en = 1'b0;
    if (ld) rf_m[ld_addr] = ld_data;
    @(negedge clk);
    check("exec_ready", instr_ready, 1'b0);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_code", alu_code, op);
    @(negedge clk);
    check("wb_valid", wb_valid, lg);
    if (lg) begin
      check("wb_addr", wb_addr, rd);
      check("wb_data", wb_data, res);
    end
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    if (lg) rf_m[rd] = res;
    if (clr) sticky_m = 1'b0;
    sets = lg && (op[4:3] == 2'b00) && v;
    if (sets) sticky_m = 1'b1;
    dbg_addr = rd; #1;
    check("wb_drop", wb_valid, 1'b0);
    check("ovf_sticky", ovf_sticky, sticky_m);
    check("dbg_rd", dbg_data, rf_m[rd]);
`ifdef ALU_SEQ_OVF_TRAP_EN
    if (sets) begin
      check("halted_set", halted, 1'b1);
      check("halt_ready", instr_ready, 1'b0);
      @(posedge clk); #1;
      check("halt_hold", halted, 1'b1);
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      sticky_m = 1'b0;
      check("halt_sticky", ovf_sticky, sticky_m);
    end
`endif
    check("ready_back", instr_ready, 1'b1);
    check("halted_low", halted, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gap;
    legal_mask = 32'h3F0F_17FF;
    rst = 1'b1; instr_valid = 1'b0; instr_op = 5'd0; instr_rd = 3'd0;
    instr_rs1 = 3'd0; instr_rs2 = 3'd0; ovf_clr = 1'b0; rf_load_en = 1'b0;
    rf_load_addr = 3'd0; rf_load_data = 16'd0; dbg_addr = 3'd0;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
    sticky_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", instr_ready, 1'b1);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 16'h0);
    check("rst_alu_a", alu_a, 16'h0);
    check("rst_alu_code", alu_code, 5'h0);
    check("rst_sticky", ovf_sticky, 1'b0);
    check("rst_halted", halted, 1'b0);

    // Signed overflow on add
    load(3'd1, 16'h7FFF); load(3'd2, 16'h0001);
    issue(5'b00000, 3'd3, 3'd1, 3'd2, 0, 0, 3'd0, 16'h0);
    // Logic op with sticky untouched
    load(3'd4, 16'hF0F0); load(3'd5, 16'h3C3C);
    issue(5'b01000, 3'd6, 3'd4, 3'd5, 0, 0, 3'd0, 16'h0);
    check("and_result", rf_m[6], 16'h3030);
    // Signed compares
    load(3'd1, 16'hFFFF); load(3'd2, 16'h0001);
    issue(5'b11001, 3'd7, 3'd1, 3'd2, 0, 0, 3'd0, 16'h0);
    issue(5'b11011, 3'd7, 3'd1, 3'd2, 0, 0, 3'd0, 16'h0);
    // Illegal ops: no writeback
    issue(5'b01011, 3'd4, 3'd1, 3'd2, 0, 0, 3'd0, 16'h0);
    issue(5'b11110, 3'd5, 3'd1, 3'd2, 0, 0, 3'd0, 16'h0);
    // Preload coincident with accept: operand sees old value
    issue(5'b00001, 3'd3, 3'd4, 3'd5, 0, 1, 3'd4, 16'h1234);
    // Overflow set and clear in the same cycle: set wins
    load(3'd1, 16'h8000); load(3'd2, 16'h0001);
    issue(5'b00001, 3'd0, 3'd1, 3'd2, 1, 0, 3'd0, 16'h0);
    if (sticky_m) clear_sticky();

    // Preload is ignored while busy
    instr_valid = 1'b1; instr_op = 5'b01001; instr_rd = 3'd6; instr_rs1 = 3'd6; instr_rs2 = 3'd6;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rf_load_en = 1'b1; rf_load_addr = 3'd5; rf_load_data = 16'hABCD;
    repeat (2) @(posedge clk); #1;
    rf_load_en = 1'b0;
    dbg_addr = 3'd5; #1;
    check("busy_load_ignored", dbg_data, rf_m[5]);

    // Held instr_valid: back-to-back accepts 3 cycles apart, RAW through rf
    load(3'd2, 16'h0123);
    instr_valid = 1'b1; instr_op = 5'b00000; instr_rd = 3'd2; instr_rs1 = 3'd2; instr_rs2 = 3'd2;
    @(posedge clk); #1;
    instr_rd = 3'd3;
    gap = 1;
    while (!instr_ready && gap < 10) begin @(posedge clk); #1; gap++; end
    check("accept_gap", gap, 3);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("raw_operand", alu_a, 16'h0246);
    @(negedge clk);
    check("raw_wb_data", wb_data, 16'h048C);
    @(posedge clk); #1;
    rf_m[2] = 16'h0246; rf_m[3] = 16'h048C;

    // Reset during EXEC aborts the instruction
    load(3'd1, 16'h1111);
    instr_valid = 1'b1; instr_op = 5'b00000; instr_rd = 3'd1; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    check("mid_rst_wb_valid", wb_valid, 1'b0);
    check("mid_rst_alu_a", alu_a, 16'h0);
    check("mid_rst_alu_b", alu_b, 16'h0);
    check("mid_rst_sticky", ovf_sticky, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      check("mid_rst_rf", dbg_data, 16'h0);
      rf_m[i] = 16'h0;
    end
    sticky_m = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", instr_ready, 1'b1);
    @(negedge clk);
    check("post_rst_no_wb", wb_valid, 1'b0);
    @(posedge clk); #1;

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), 16'($urandom));
      if (sticky_m && $urandom_range(0, 3) == 0) clear_sticky();
      issue(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
